// File: rtl/key_entry_ctrl.sv
// ---------------------------------------------------------------------------
// key_entry_ctrl
//   Turns a stream of PS/2 scan codes into a complete hex key for the A5/1
//   cipher key-load logic. F0 (break) and E0 (extended) prefixes are stripped.
//   Make codes 0-9/A-F are shifted in as nibbles, and the first digit typed
//   ends up in the MSB nibble. Backspace removes the last digit. Esc clears
//   the key. Enter presents a full key on key_out/key_valid, and the key is
//   held until key_ack.
//
//   Optional feature macro: KEY_ENTRY_ECHO_EN
//     Adds echo_digit/echo_stb. Each accepted digit is echoed on these ports
//     for a 7-segment display.
//
// Ports
//   clock        in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-high
//   scan_code    in   8      received PS/2 byte
//   scan_valid   in   1      1-cycle strobe, scan_code valid
//   key_ack      in   1      consumer accepted key_out
//   key_out      out  KEY_W  assembled key
//   key_valid    out  1      key complete, held until key_ack
//   digit_count  out  CNT_W  digits currently entered, 0..NDIGITS
//   entry_err    out  1      1-cycle pulse on a rejected action
//   echo_digit   out  4      (KEY_ENTRY_ECHO_EN) last accepted nibble
//   echo_stb     out  1      (KEY_ENTRY_ECHO_EN) pulse per accepted digit
// ---------------------------------------------------------------------------
module key_entry_ctrl #(
    parameter  int NDIGITS = 16,
    parameter  int CNT_W   = 5,
    localparam int KEY_W   = 4 * NDIGITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       scan_code,
    input  logic             scan_valid,
    input  logic             key_ack,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic [CNT_W-1:0] digit_count,
    output logic             entry_err
`ifdef KEY_ENTRY_ECHO_EN
    ,
    output logic [3:0]       echo_digit,
    output logic             echo_stb
`endif
);

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(NDIGITS);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic {ENTRY, DONE} mode_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] nib;
    } hex_t;

    // Set 2 make codes for the hex keys. Any code not listed here reports
    // hit=0, so an unknown key can never be entered as digit 0.
    function automatic hex_t hex_decode(input logic [7:0] code);
        hex_t r;
        r.hit = 1'b1;
        r.nib = 4'h0;
        case (code)
            8'h45: r.nib = 4'h0;
            8'h16: r.nib = 4'h1;
            8'h1E: r.nib = 4'h2;
            8'h26: r.nib = 4'h3;
            8'h25: r.nib = 4'h4;
            8'h2E: r.nib = 4'h5;
            8'h36: r.nib = 4'h6;
            8'h3D: r.nib = 4'h7;
            8'h3E: r.nib = 4'h8;
            8'h46: r.nib = 4'h9;
            8'h1C: r.nib = 4'hA;
            8'h32: r.nib = 4'hB;
            8'h21: r.nib = 4'hC;
            8'h23: r.nib = 4'hD;
            8'h24: r.nib = 4'hE;
            8'h2B: r.nib = 4'hF;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

    mode_t mode;
    logic  brk;
    logic  ext;
    hex_t  dec;

    assign dec = hex_decode(scan_code);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode        <= ENTRY;
            brk         <= 1'b0;
            ext         <= 1'b0;
            key_out     <= '0;
            key_valid   <= 1'b0;
            digit_count <= '0;
            entry_err   <= 1'b0;
`ifdef KEY_ENTRY_ECHO_EN
            echo_digit  <= 4'h0;
            echo_stb    <= 1'b0;
`endif
        end else begin
            entry_err <= 1'b0;
`ifdef KEY_ENTRY_ECHO_EN
            echo_stb  <= 1'b0;
`endif
            // The ack is only honoured in DONE. It never collides with the
            // ENTRY key handling below, so a byte that arrives in the same
            // cycle can only affect the prefix state.
            if (mode == DONE && key_ack) begin
                mode        <= ENTRY;
                key_valid   <= 1'b0;
                key_out     <= '0;
                digit_count <= '0;
            end

            if (scan_valid) begin
                if (scan_code == SC_BREAK) begin
                    brk <= 1'b1;
                end else if (scan_code == SC_EXT) begin
                    ext <= 1'b1;
                end else if (brk) begin
                    // This byte is the key-release code, so drop it.
                    brk <= 1'b0;
                    ext <= 1'b0;
                end else begin
                    ext <= 1'b0;
                    if (mode == ENTRY) begin
                        if (dec.hit && !ext) begin
                            if (digit_count < FULL) begin
                                key_out     <= {key_out[KEY_W-5:0], dec.nib};
                                digit_count <= digit_count + ONE;
`ifdef KEY_ENTRY_ECHO_EN
                                echo_digit  <= dec.nib;
                                echo_stb    <= 1'b1;
`endif
                            end else begin
                                entry_err <= 1'b1;
                            end
                        end else if (scan_code == SC_BKSP) begin
                            if (digit_count != '0) begin
                                key_out     <= key_out >> 4;
                                digit_count <= digit_count - ONE;
                            end
                        end else if (scan_code == SC_ESC) begin
                            key_out     <= '0;
                            digit_count <= '0;
                        end else if (scan_code == SC_ENTER) begin
                            // The keypad Enter (E0 5A) is accepted like the main Enter.
                            if (digit_count == FULL) begin
                                key_valid <= 1'b1;
                                mode      <= DONE;
                            end else begin
                                entry_err <= 1'b1;
                            end
                        end
                        // An extended hex code or any other byte is ignored silently.
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_key_entry_ctrl.sv
module tb_key_entry_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  scan_code;
    logic        scan_valid;
    logic        key_ack;
    logic [63:0] key_out;
    logic        key_valid;
    logic [4:0]  digit_count;
    logic        entry_err;
`ifdef KEY_ENTRY_ECHO_EN
    logic [3:0]  echo_digit;
    logic        echo_stb;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] mk [16];

    always #5 clock = ~clock;

    key_entry_ctrl #(.NDIGITS(16), .CNT_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .key_ack    (key_ack),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .digit_count(digit_count),
        .entry_err  (entry_err)
`ifdef KEY_ENTRY_ECHO_EN
        ,
        .echo_digit (echo_digit),
        .echo_stb   (echo_stb)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Each byte is strobed for one cycle. The task returns on the following
    // negedge, where the registered result is already visible.
    task automatic send(input logic [7:0] b);
        @(negedge clock);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clock);
        scan_valid = 1'b0;
    endtask

    task automatic fill_key;
        for (int i = 0; i < 16; i++) send(mk[i]);
    endtask

    task automatic pulse_ack;
        @(negedge clock);
        key_ack = 1'b1;
        @(negedge clock);
        key_ack = 1'b0;
    endtask

    initial begin
        mk = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
               8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
        reset = 1'b1; scan_code = 8'h00; scan_valid = 1'b0; key_ack = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_key",   key_out,     64'h0);
        chk("rst_count", 64'(digit_count), 64'd0);
        chk("rst_valid", 64'(key_valid),   64'd0);
        chk("rst_err",   64'(entry_err),   64'd0);
        reset = 1'b0;

        // 1: make/break pairs for 0..F, then Enter
        for (int i = 0; i < 16; i++) begin
            send(mk[i]); send(8'hF0); send(mk[i]);
        end
        chk("t1_count", 64'(digit_count), 64'd16);
        chk("t1_key",   key_out, 64'h0123456789ABCDEF);
        chk("t1_valid_pre", 64'(key_valid), 64'd0);
        send(8'h5A);
        chk("t1_valid", 64'(key_valid), 64'd1);
        chk("t1_key_done", key_out, 64'h0123456789ABCDEF);
        send(8'h16);
        chk("t1_done_frozen", 64'(digit_count), 64'd16);
        pulse_ack;
        chk("t1_ack_valid", 64'(key_valid), 64'd0);
        chk("t1_ack_key",   key_out, 64'h0);
        chk("t1_ack_count", 64'(digit_count), 64'd0);

        // 2: 1, 2, Backspace, 3, then Enter with an incomplete key
        send(8'h16); send(8'h1E); send(8'h66); send(8'h26);
        chk("t2_count", 64'(digit_count), 64'd2);
        chk("t2_key",   key_out, 64'h13);
        send(8'h5A);
        chk("t2_err",   64'(entry_err), 64'd1);
        chk("t2_valid", 64'(key_valid), 64'd0);
        chk("t2_count_kept", 64'(digit_count), 64'd2);
        @(negedge clock);
        chk("t2_err_pulse", 64'(entry_err), 64'd0);

        // 3: overflow digit, then Esc, then Backspace at an empty key
        send(8'h76);
        fill_key;
        send(8'h3D);
        chk("t3_err",   64'(entry_err), 64'd1);
        chk("t3_key",   key_out, 64'h0123456789ABCDEF);
        chk("t3_count", 64'(digit_count), 64'd16);
        send(8'h76);
        chk("t3_esc_key",   key_out, 64'h0);
        chk("t3_esc_count", 64'(digit_count), 64'd0);
        send(8'h66);
        chk("t3_bksp0_count", 64'(digit_count), 64'd0);
        chk("t3_bksp0_err",   64'(entry_err), 64'd0);

        // 4: ack arrives in the same cycle as F0 while in DONE
        fill_key;
        send(8'h5A);
        chk("t4_valid", 64'(key_valid), 64'd1);
        @(negedge clock);
        scan_code = 8'hF0; scan_valid = 1'b1; key_ack = 1'b1;
        @(negedge clock);
        scan_valid = 1'b0; key_ack = 1'b0;
        chk("t4_ack_valid", 64'(key_valid), 64'd0);
        chk("t4_ack_count", 64'(digit_count), 64'd0);
        send(8'h16);
        chk("t4_break_discard", 64'(digit_count), 64'd0);
        send(8'h16);
        chk("t4_next_count", 64'(digit_count), 64'd1);
        chk("t4_next_key",   key_out, 64'h1);
        // In ENTRY, key_ack has no effect.
        pulse_ack;
        chk("t4_ack_entry", 64'(digit_count), 64'd1);

        // 5: an extended hex code is ignored and the keypad Enter is accepted
        send(8'h76);
        fill_key;
        send(8'hE0); send(8'h45);
        chk("t5_ext_count", 64'(digit_count), 64'd16);
        chk("t5_ext_err",   64'(entry_err), 64'd0);
        chk("t5_ext_key",   key_out, 64'h0123456789ABCDEF);
        send(8'hE0); send(8'h5A);
        chk("t5_kp_enter", 64'(key_valid), 64'd1);
        pulse_ack;
        send(8'h55);
        chk("t5_unk_count", 64'(digit_count), 64'd0);
        chk("t5_unk_err",   64'(entry_err), 64'd0);
        send(8'hE0); send(8'h16);
        chk("t5_ext_low", 64'(digit_count), 64'd0);
        send(8'h16);
        chk("t5_ext_cleared", 64'(digit_count), 64'd1);

        // 6: async reset after 5 digits and a lone F0
        send(8'h76);
        for (int i = 0; i < 5; i++) send(mk[i]);
        send(8'hF0);
        chk("t6_pre_count", 64'(digit_count), 64'd5);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("t6_rst_key",   key_out, 64'h0);
        chk("t6_rst_count", 64'(digit_count), 64'd0);
        chk("t6_rst_valid", 64'(key_valid), 64'd0);
        chk("t6_rst_err",   64'(entry_err), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        send(8'h1C);
        chk("t6_a_count", 64'(digit_count), 64'd1);
        chk("t6_a_key",   key_out, 64'hA);
`ifdef KEY_ENTRY_ECHO_EN
        chk("t6_echo_stb",   64'(echo_stb), 64'd1);
        chk("t6_echo_digit", 64'(echo_digit), 64'hA);
        @(negedge clock);
        chk("t6_echo_stb_off", 64'(echo_stb), 64'd0);
        chk("t6_echo_hold",    64'(echo_digit), 64'hA);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
